// File: rtl/adder_seq_pkg.sv
// ---------------------------------------------------------------------------
// adder_seq_pkg
// Shared definitions for the nibble-serial add/subtract engine:
//   - FSM state encodings (IDLE / RUN / DONE)
//   - nibble width of the shared datapath adder
//   - helper to size the nibble index counter
// ---------------------------------------------------------------------------
package adder_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int NIBBLE_W = 4;

    // Width of the nibble index counter: clog2(nib), never less than 1 so a
    // single-nibble configuration still has a legal (constant-zero) counter.
    function automatic int idx_width(input int nib);
        int w;
        w = $clog2(nib);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/adder4bit.sv
// ---------------------------------------------------------------------------
// adder4bit
// Plain 4-bit ripple adder used as the shared nibble datapath.
// Ports:
//   A, B  : 4-bit addends
//   Cin   : carry in
//   Sum   : 4-bit sum
//   Cout  : carry out
// ---------------------------------------------------------------------------
module adder4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

// File: rtl/adder_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// adder_nibble_sequencer
// Multi-cycle WIDTH-bit add/subtract engine. A single adder4bit is reused
// once per clock, LSB nibble first, with a registered carry chaining the
// nibbles. Valid/ready handshakes on the operand and result sides.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : operand handshake (accepted only in IDLE)
//   op_a, op_b        : operands
//   cin               : carry-in for add (ignored for subtract)
//   sub               : 1 = A - B, 0 = A + B + cin
//   out_valid/out_ready : result handshake (result held while stalled)
//   sum, cout         : result and carry-out (for subtract, 1 = no borrow)
//   overflow          : signed overflow of the final result
//   busy              : high while an operation is in RUN or DONE
//
// WIDTH must be a multiple of 4 and at least 4.
// ---------------------------------------------------------------------------
module adder_nibble_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;

    // Current nibble of each operand register feeds the shared adder.
    assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    adder4bit u_adder4bit (
        .A    (nib_a),
        .B    (nib_b),
        .Cin  (carry_q),
        .Sum  (nib_sum),
        .Cout (nib_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1: invert B here and seed the
                    // carry with 1 so the datapath is always an adder.
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
                carry_d = nib_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = nib_cout;
                    // Operand signs agree but result sign differs. b_q already
                    // holds ~B for subtract, so this covers both operations;
                    // nib_sum[3] is the final result MSB.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (nib_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adder_nibble_sequencer
// Directed bench for adder_nibble_sequencer (WIDTH = 16).
// ---------------------------------------------------------------------------
module tb_adder_nibble_sequencer;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    adder_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for the result, check latency and values, retire.
    task automatic run_op(input string tag,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb,
                          input logic [15:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf);
        int cyc;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        op_a = a; op_b = b; cin = ci; sub = sb; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op_a = 16'hDEAD; op_b = 16'hBEEF; cin = ~ci; sub = ~sb;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check({tag, "_latency"},  cyc,                   32'd4);
        check({tag, "_sum"},      {16'd0, sum},          {16'd0, exp_sum});
        check({tag, "_cout"},     {31'd0, cout},         {31'd0, exp_cout});
        check({tag, "_overflow"}, {31'd0, overflow},     {31'd0, exp_ovf});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_retired"},  {31'd0, out_valid},    32'd0);
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_sum",       {16'd0, sum},       32'd0);
        check("rst_cout",      {31'd0, cout},      32'd0);
        check("rst_overflow",  {31'd0, overflow},  32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Arithmetic vectors
        run_op("add_basic",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_cin",    16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_pos",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: result held, new operands refused while busy
        op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        step();
        op_a = 16'h0001; op_b = 16'h0001;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            check("bp_run_in_ready", {31'd0, in_ready}, 32'd0);
            step();
            cyc++;
        end
        check("bp_latency", cyc, 32'd4);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid",    {31'd0, out_valid}, 32'd1);
            check("bp_hold_sum",      {16'd0, sum},       32'h3333);
            check("bp_hold_cout",     {31'd0, cout},      32'd0);
            check("bp_hold_overflow", {31'd0, overflow},  32'd0);
            check("bp_hold_in_ready", {31'd0, in_ready},  32'd0);
            step();
        end
        // Retire with in_valid still high: new op must not be taken this edge
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_retire_valid", {31'd0, out_valid}, 32'd0);
        check("bp_retire_busy",  {31'd0, busy},      32'd0);
        check("bp_retire_ready", {31'd0, in_ready},  32'd1);
        step();
        in_valid = 1'b0;
        op_a = 16'hFFFF;
        check("bp_next_accept_busy", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check("bp_next_latency", cyc, 32'd4);
        check("bp_next_sum", {16'd0, sum}, 32'h0002);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset two cycles into RUN
        op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_sum",       {16'd0, sum},       32'd0);
        check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("mid_rst_busy",      {31'd0, busy},      32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
